// File: rtl/sat_adder.sv
// 16-bit saturating adder/subtractor built from four 4-bit carry-lookahead slices.
// Sum and Ovfl are registered, giving one cycle of latency.
module sat_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Sub,
    output logic [15:0] Sum,
    output logic        Ovfl
);

    logic [15:0] bop;
    logic [15:0] raw;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_c;
    logic        pos_ovf;
    logic        neg_ovf;
    logic [15:0] sum_d;
    logic [15:0] sum_q;
    logic        ovfl_d;
    logic        ovfl_q;

    assign bop      = Sub ? ~B : B;
    assign grp_c[0] = Sub;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;

            assign g = A[gi*4 +: 4] & bop[gi*4 +: 4];
            assign p = A[gi*4 +: 4] ^ bop[gi*4 +: 4];

            assign c[0] = grp_c[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);

            assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                             | (p[3] & p[2] & p[1] & g[0]);
            assign grp_p[gi] = &p;

            assign raw[gi*4 +: 4] = p ^ c;

            // The carry out of the top slice is unsigned and deliberately dropped.
            if (gi < 3) begin : g_chain
                assign grp_c[gi+1] = grp_g[gi] | (grp_p[gi] & grp_c[gi]);
            end
        end
    endgenerate

    always_comb begin
        pos_ovf = ~A[15] & ~bop[15] &  raw[15];
        neg_ovf =  A[15] &  bop[15] & ~raw[15];
        sum_d   = raw;
        ovfl_d  = pos_ovf | neg_ovf;
        if (pos_ovf) begin
            sum_d = 16'h7FFF;
        end else if (neg_ovf) begin
            sum_d = 16'h8000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= 16'h0000;
            ovfl_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            ovfl_q <= ovfl_d;
        end
    end

    assign Sum  = sum_q;
    assign Ovfl = ovfl_q;

endmodule

// File: tb/tb_sat_adder.sv
// Self-checking bench for sat_adder: directed boundary vectors, latency,
// asynchronous reset and randomized vectors against an integer model.
module tb_sat_adder;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Sub;
    logic [15:0] Sum;
    logic        Ovfl;

    int checks   = 0;
    int failures = 0;

    sat_adder dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Sub  (Sub),
        .Sum  (Sum),
        .Ovfl (Ovfl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Golden model: exact signed result in 32 bits, clamped to the 16-bit range.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        int ia;
        int ib;
        int r;
        logic [31:0] ru;
        ia = $signed(a);
        ib = $signed(b);
        r  = s ? ia - ib : ia + ib;
        if (r > 32767) return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        ru = r;
        return {1'b0, ru[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        A   = 16'h1234;
        B   = 16'h4321;
        Sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got Sum=%h Ovfl=%b want Sum=0000 Ovfl=0", Sum, Ovfl);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (Sum !== 16'h5555 || Ovfl !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got Sum=%h Ovfl=%b want Sum=5555 Ovfl=0", Sum, Ovfl);
        end
        $display("reset: Sum=%h Ovfl=%b", Sum, Ovfl);
    endtask

    task automatic test_directed();
        logic [15:0] ta [7] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 16'h0000};
        logic [15:0] tb [7] = '{16'h0212, 16'h0001, 16'h8001, 16'h0001, 16'h8000, 16'h0001, 16'h0000};
        logic        ts [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] es [7] = '{16'h1022, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000};
        logic        eo [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            A   = ta[i];
            B   = tb[i];
            Sub = ts[i];
            @(posedge clk);
            #1;
            checks++;
            if (Sum !== es[i] || Ovfl !== eo[i]) begin
                failures++;
                $display("FAIL directed_%0d: A=%h B=%h Sub=%b got Sum=%h Ovfl=%b want Sum=%h Ovfl=%b",
                         i, ta[i], tb[i], ts[i], Sum, Ovfl, es[i], eo[i]);
            end
            $display("directed %0d: A=%h B=%h Sub=%b Sum=%h Ovfl=%b", i, ta[i], tb[i], ts[i], Sum, Ovfl);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] prev;
        logic [16:0] exp;
        prev = {Ovfl, Sum};
        for (int i = 0; i < 20; i++) begin
            A   = 16'($urandom);
            B   = 16'($urandom);
            Sub = 1'($urandom);
            exp = model(A, B, Sub);
            #1;
            checks++;
            if ({Ovfl, Sum} !== prev) begin
                failures++;
                $display("FAIL latency_early_%0d: got Sum=%h Ovfl=%b before edge, want Sum=%h Ovfl=%b",
                         i, Sum, Ovfl, prev[15:0], prev[16]);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({Ovfl, Sum} !== exp) begin
                failures++;
                $display("FAIL latency_%0d: A=%h B=%h Sub=%b got Sum=%h Ovfl=%b want Sum=%h Ovfl=%b",
                         i, A, B, Sub, Sum, Ovfl, exp[15:0], exp[16]);
            end
            $display("b2b %0d: A=%h B=%h Sub=%b Sum=%h Ovfl=%b", i, A, B, Sub, Sum, Ovfl);
            prev = exp;
        end
    endtask

    task automatic test_async_reset();
        A   = 16'h7FFF;
        B   = 16'h7FFF;
        Sub = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (Sum !== 16'h7FFF || Ovfl !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: got Sum=%h Ovfl=%b want Sum=7FFF Ovfl=1", Sum, Ovfl);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: got Sum=%h Ovfl=%b want Sum=0000 Ovfl=0 before edge", Sum, Ovfl);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
            failures++;
            $display("FAIL async_hold: got Sum=%h Ovfl=%b want Sum=0000 Ovfl=0", Sum, Ovfl);
        end
        rst = 1'b0;
        A   = 16'h0001;
        B   = 16'h0002;
        Sub = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (Sum !== 16'hFFFF || Ovfl !== 1'b0) begin
            failures++;
            $display("FAIL async_release: got Sum=%h Ovfl=%b want Sum=FFFF Ovfl=0", Sum, Ovfl);
        end
        $display("async reset: Sum=%h Ovfl=%b", Sum, Ovfl);
    endtask

    task automatic test_random();
        logic [15:0] special [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF};
        logic [16:0] exp;
        int          bad;
        int          sat;
        bad = 0;
        sat = 0;
        for (int i = 0; i < 10000; i++) begin
            A   = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : 16'($urandom);
            B   = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : 16'($urandom);
            Sub = 1'($urandom);
            exp = model(A, B, Sub);
            @(posedge clk);
            #1;
            checks++;
            if ({Ovfl, Sum} !== exp) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d: A=%h B=%h Sub=%b got Sum=%h Ovfl=%b want Sum=%h Ovfl=%b",
                             i, A, B, Sub, Sum, Ovfl, exp[15:0], exp[16]);
            end
            if (exp[16]) sat++;
        end
        $display("random: 10000 vectors, %0d saturating, %0d bad", sat, bad);
    endtask

    initial begin
        rst = 1'b1;
        A   = 16'h0000;
        B   = 16'h0000;
        Sub = 1'b0;
        #1;
        checks++;
        if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: got Sum=%h Ovfl=%b want Sum=0000 Ovfl=0", Sum, Ovfl);
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
